// File: rtl/instruction_sequencer_if.sv
// Purpose: bundles the program-load port, the launch controls and the
// control_unit handshake of instruction_sequencer into one interface.
// Signals:
//   prog_we / prog_addr / prog_data : program RAM write port
//   last_addr                       : address of the final instruction
//   start                           : level request to run the program
//   done                            : instruction retired by control_unit
//   instruction / run               : word and request presented to control_unit
//   pc                              : address of the instruction being issued
//   busy / prog_done / error        : status flags
// Modports: master is the sequencer side, slave is the environment side.
interface instruction_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [ADDR_W-1:0] last_addr;
  logic              start;
  logic              done;
  logic [15:0]       instruction;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              prog_done;
  logic              error;

  modport master (
    input  prog_we, prog_addr, prog_data, last_addr, start, done,
    output instruction, run, pc, busy, prog_done, error
  );

  modport slave (
    output prog_we, prog_addr, prog_data, last_addr, start, done,
    input  instruction, run, pc, busy, prog_done, error
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Purpose: upstream feeder for control_unit. Holds a 2**ADDR_W x 16 program
// RAM loaded over a write port. On start it issues words 0..last_addr one at a
// time, holding run high until control_unit answers with done, and drops run
// for one FETCH cycle between words so every instruction gets a fresh run
// rising edge. A watchdog moves to ERROR if done never arrives.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset (RAM contents are kept)
//   bus    : instruction_sequencer_if.master (program port, start/last_addr,
//            done in; instruction, run, pc, busy, prog_done, error out)
// Parameters:
//   ADDR_W  : program address width
//   TIMEOUT : ISSUE cycles allowed without done before ERROR (keep >= 4 so a
//             normal 4-cycle control_unit handshake always fits)
module instruction_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_sequencer_if.master  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    FIN,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] last;
  logic [15:0]       instruction;
  logic [WD_W-1:0]   wd;
  logic              launch;
  logic              advance;
  logic              prog_open;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs. launch restarts from word 0
  // (from IDLE or after a watchdog trip); advance steps to the next word
  // once control_unit retires the current one. done beats the watchdog when
  // both land in the same cycle.
  always_comb begin
    state_next    = state;
    launch        = 1'b0;
    advance       = 1'b0;
    prog_open     = 1'b0;
    bus.run       = 1'b0;
    bus.busy      = 1'b0;
    bus.prog_done = 1'b0;
    bus.error     = 1'b0;
    case (state)
      IDLE: begin
        prog_open = 1'b1;
        if (bus.start) begin
          state_next = FETCH;
          launch     = 1'b1;
        end
      end
      FETCH: begin
        bus.busy   = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        bus.busy = 1'b1;
        bus.run  = 1'b1;
        if (bus.done) begin
          if (pc == last) begin
            state_next = FIN;
          end else begin
            state_next = FETCH;
            advance    = 1'b1;
          end
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          state_next = ERROR;
        end
      end
      FIN: begin
        bus.prog_done = 1'b1;
        state_next    = IDLE;
      end
      ERROR: begin
        prog_open = 1'b1;
        bus.error = 1'b1;
        if (bus.start) begin
          state_next = FETCH;
          launch     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Program RAM write port. Writes are only accepted while the sequencer is
  // not executing; a write in the same cycle as start lands before FETCH
  // reads the array, so the new word is issued.
  always_ff @(posedge clk) begin
    if (bus.prog_we && prog_open) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Datapath: pc and the latched last address, the synchronous RAM read into
  // the instruction register during FETCH, and the watchdog counter that is
  // zero on the first ISSUE cycle and counts up while waiting for done.
  // A restart from ERROR relatches last_addr just like a launch from IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      last        <= '0;
      instruction <= '0;
      wd          <= '0;
    end else begin
      if (launch) begin
        pc   <= '0;
        last <= bus.last_addr;
      end else if (advance) begin
        pc <= pc + 1'b1;
      end
      if (state == FETCH) begin
        instruction <= mem[pc];
      end
      if (state == ISSUE) begin
        wd <= wd + 1'b1;
      end else begin
        wd <= '0;
      end
    end
  end

  assign bus.instruction = instruction;
  assign bus.pc          = pc;

endmodule
